reg_ctrl: RTL and testbench
===========================

# reg_ctrl

Multi-cycle control unit that sequences the byter register file. Accepts 16-bit instructions through a valid/ready handshake, decodes them, and drives the register file's write strobes (`regEnable`, `litEnable`, `memEnable`), register selects (`SA`, `SB`) and literal bus. It also drives the data-memory request handshake and program-counter controls. It sits between the instruction source and `reg_module`/memory/PC.

## Interface
- `MEM_TIMEOUT`, default 15: max cycles waiting for `mem_ack` before abort; 4-bit counter, legal range 1–15.
- `clk`  in  1: system clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `instr_valid`  in  1: `instr` holds a valid instruction.
- `instr`  in  16: `[15:12]` opcode, `[11:8]` ra, `[7:4]` rb, `[7:0]` imm.
- `instr_ready`  out  1: controller can accept an instruction.
- `mem_ack`  in  1: memory completed the current request.
- `mem_req`  out  1: memory request, held until ack or timeout.
- `mem_we`  out  1: request is a write; valid with `mem_req`.
- `regEnable`, `litEnable`, `memEnable`  out  1 each: register-file strobes.
- `SA`, `SB`  out  4 each: register selects.
- `lit`  out  8: literal to register 14.
- `pc_inc`  out  1: one-cycle PC increment pulse.
- `pc_load`  out  1: one-cycle PC load pulse; PC takes `{r13[3:0], r12}`.
- `halted`  out  1: HALT executed.
- `err`  out  1: one-cycle pulse on illegal opcode or memory timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM_WAIT, HALT.
- FETCH:
  - `instr_ready`=1.
  - On `instr_valid`, latch `instr` and go to DECODE.
- DECODE:
  - One cycle; `SA`/`SB` driven from ra/rb; no strobes.
  - Next state is EXEC.
- EXEC, by opcode (every path back to FETCH pulses `pc_inc` in that cycle except JMP):
  - 0x0 NOP: no strobes.
  - 0x1 MOV: `regEnable`=1; writes ALU/data bus to `SA`=ra.
  - 0x2 LDI: `regEnable`=`litEnable`=1, `lit`=imm; writes r14.
  - 0x3 LD: `memEnable`=1, `mem_req`=1, `mem_we`=0; go to MEM_WAIT.
  - 0x4 ST: `memEnable`=1, `mem_req`=1, `mem_we`=1; go to MEM_WAIT.
  - 0x5 JMP: `pc_load`=1, no `pc_inc`.
  - 0xF HALT: go to HALT.
  - Other opcodes: behave as NOP and pulse `err`.
- MEM_WAIT:
  - Holds `memEnable`, `mem_req` and `mem_we`.
  - Counter starts at 0 on entry and increments each cycle without ack.
  - On `mem_ack`: LD additionally asserts `regEnable` that cycle, writing r15. Deassert `mem_req`, pulse `pc_inc`, go to FETCH.
  - When counter reaches `MEM_TIMEOUT` without ack: pulse `err`, drop `mem_req`, no register write, pulse `pc_inc`, go to FETCH.
- HALT:
  - `halted`=1, `instr_ready`=0; the state is terminal until `reset`.
- Strobes are never active in FETCH or DECODE.
- `litEnable` and `memEnable` are never both 1.

## Timing
- Reset: state FETCH; all outputs 0 (`instr_ready` rises in the first cycle after reset deasserts); latched instruction and counter cleared.
- Reset mid-operation aborts any state, including MEM_WAIT with `mem_req` high. The next cycle shows all outputs 0; a late `mem_ack` is ignored.
- Latency from accept edge:
  - NOP/MOV/LDI/JMP/illegal: strobes in EXEC, 2 cycles after accept; next `instr_ready` 3 cycles after accept.
  - LD/ST: the register write (LD) and `pc_inc` occur in the ack cycle.
  - An ack in the first MEM_WAIT cycle gives 4 cycles accept-to-ready.
- Outputs are registered from state; `mem_ack` combinationally qualifies `regEnable`/`pc_inc` in MEM_WAIT only.
- `mem_ack` outside MEM_WAIT is ignored.

## Structure
- Shared package `byter_pkg`: opcode constants, state enum, register indices (`R_PCL`=12, `R_PCH`=13, `R_LIT`=14, `R_MEM`=15).
- Single module; no sub-module needed. The timeout counter stays inline.

## Test plan
- After reset, with no stimulus: all outputs 0; `instr_ready`=1 the cycle after reset drops.
- LDI `0x20A5`: `regEnable`=`litEnable`=1 and `lit`=0xA5 for exactly one cycle; `pc_inc` that cycle; `instr_ready` 3 cycles after accept.
- LD `0x3000` with ack after 3 waits: `mem_req`/`memEnable` high 4 cycles, `mem_we`=0; `regEnable`=1 only in the ack cycle.
- ST with no ack and `MEM_TIMEOUT`=4: `mem_req` high 5 cycles (EXEC + 4); `err` pulses once; no `regEnable`; back to FETCH.
- Opcode 0x7, then HALT `0xF000`: `err` pulses once with `pc_inc`; after HALT, `halted`=1 and `instr_ready` stays 0 for 20 cycles; `reset` clears both.
- JMP `0x5000`: `pc_load` pulses one cycle with `pc_inc`=0; `reset` asserted during a LD MEM_WAIT drops `mem_req` the next cycle.

Source files
------------

// File: rtl/byter_pkg.sv
// Shared definitions for the byter control path: opcodes, controller states
// and fixed register indices used by reg_ctrl.
package byter_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] R_PCL = 4'd12;
  localparam logic [3:0] R_PCH = 4'd13;
  localparam logic [3:0] R_LIT = 4'd14;
  localparam logic [3:0] R_MEM = 4'd15;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/reg_ctrl.sv
// Multi-cycle sequencer for the byter register file: fetch/decode/execute with
// a memory wait state guarded by a timeout counter.
//
// state    | meaning
// FETCH    | ready for an instruction, latch on instr_valid
// DECODE   | register selects from ra/rb, no strobes
// EXEC     | opcode-specific strobes / PC controls
// MEM_WAIT | memory request held until ack or timeout
// HALT     | terminal until reset
module reg_ctrl
  import byter_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        regEnable,
  output logic        litEnable,
  output logic        memEnable,
  output logic [3:0]  SA,
  output logic [3:0]  SB,
  output logic [7:0]  lit,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic        err
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [3:0] op, ra, rb;
  logic [7:0] imm;
  logic       timeout_hit;

  assign op  = instr_q[15:12];
  assign ra  = instr_q[11:8];
  assign rb  = instr_q[7:4];
  assign imm = instr_q[7:0];

  assign timeout_hit = (state_q == MEM_WAIT) && !mem_ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      instr_q <= 16'h0000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_mem_op(op)) begin
          cnt_d   = 4'd0;
          state_d = MEM_WAIT;
        end else if (op == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      MEM_WAIT: begin
        if (mem_ack || timeout_hit) begin
          cnt_d   = 4'd0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Ready is held low while reset is applied so the reset cycle shows all-zero outputs.
  always_comb begin
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    regEnable   = 1'b0;
    litEnable   = 1'b0;
    memEnable   = 1'b0;
    SA          = 4'd0;
    SB          = 4'd0;
    lit         = 8'h00;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;
    case (state_q)
      FETCH: instr_ready = !reset;
      DECODE: begin
        SA = ra;
        SB = rb;
      end
      EXEC: begin
        SA = ra;
        SB = rb;
        case (op)
          OP_NOP: pc_inc = 1'b1;
          OP_MOV: begin
            regEnable = 1'b1;
            pc_inc    = 1'b1;
          end
          OP_LDI: begin
            regEnable = 1'b1;
            litEnable = 1'b1;
            lit       = imm;
            SA        = R_LIT;
            pc_inc    = 1'b1;
          end
          OP_LD, OP_ST: begin
            memEnable = 1'b1;
            mem_req   = 1'b1;
            mem_we    = (op == OP_ST);
          end
          OP_JMP: begin
            pc_load = 1'b1;
            SA      = R_PCH;
            SB      = R_PCL;
          end
          OP_HALT: ;
          default: begin
            pc_inc = 1'b1;
            err    = !is_legal_op(op);
          end
        endcase
      end
      MEM_WAIT: begin
        memEnable = 1'b1;
        mem_req   = 1'b1;
        mem_we    = (op == OP_ST);
        SA        = (op == OP_LD) ? R_MEM : ra;
        SB        = rb;
        regEnable = mem_ack && (op == OP_LD);
        pc_inc    = mem_ack || timeout_hit;
        err       = timeout_hit;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_ctrl.sv
// Scoreboard bench for reg_ctrl: stimulus queues hand-computed output events,
// a negedge monitor compares every cycle where the controller drives an action.
module tb_reg_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        instr_ready, mem_req, mem_we, regEnable, litEnable, memEnable;
  logic [3:0]  SA, SB;
  logic [7:0]  lit;
  logic        pc_inc, pc_load, halted, err;

  reg_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .regEnable(regEnable), .litEnable(litEnable), .memEnable(memEnable),
    .SA(SA), .SB(SB), .lit(lit), .pc_inc(pc_inc), .pc_load(pc_load),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];

  // {regEnable, litEnable, memEnable, mem_req, mem_we, pc_inc, pc_load, err, lit, SA, SB}
  wire [23:0] obs = {regEnable, litEnable, memEnable, mem_req, mem_we, pc_inc, pc_load, err,
                     lit, SA, SB};
  wire [25:0] all_out = {obs, instr_ready, halted};

  function automatic logic [23:0] ev(input logic re, le, me, rq, we, pi, pl, er,
                                     input logic [7:0] l, input logic [3:0] sa, sb);
    return {re, le, me, rq, we, pi, pl, er, l, sa, sb};
  endfunction

  always @(negedge clk) begin
    logic [23:0] e;
    if (|obs[23:16]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event t=%0t got=%h required=none", $time, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL event t=%0t got=%h required=%h", $time, obs, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  // Returns #1 after the accept edge (start of DECODE cycle).
  task automatic accept(input logic [15:0] i);
    int n = 0;
    instr = i;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!instr_ready) begin
      errors++;
      $display("FAIL accept_timeout got=ready0 required=ready1");
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready(input int ack_at, input int exp_lat, input string name);
    int c = 1;
    int lat = 0;
    while (c <= 40 && lat == 0) begin
      if (instr_ready) lat = c;
      else begin
        mem_ack = (c == ack_at);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        c++;
      end
    end
    check(name, lat, exp_lat);
  endtask

  task automatic run(input logic [15:0] i, input int ack_at, input int exp_lat, input string name);
    accept(i);
    wait_ready(ack_at, exp_lat, name);
  endtask

  initial begin
    int bad;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(all_out), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {31'h0, instr_ready}, 32'h1);
    check("idle_outputs", 32'(obs), 32'h0);

    exp_q.push_back(ev(1,1,0,0,0,1,0,0,8'hA5,4'd14,4'hA));
    run(16'h20A5, 0, 3, "ldi_latency");

    exp_q.push_back(ev(1,0,0,0,0,1,0,0,8'h00,4'd2,4'd3));
    run(16'h1230, 0, 3, "mov_latency");

    exp_q.push_back(ev(0,0,0,0,0,1,0,0,8'h00,4'hC,4'h4));
    run(16'h0C40, 0, 3, "nop_latency");

    exp_q.push_back(ev(0,0,1,1,0,0,0,0,8'h00,4'd4,4'd5));
    exp_q.push_back(ev(0,0,1,1,0,0,0,0,8'h00,4'd15,4'd5));
    exp_q.push_back(ev(0,0,1,1,0,0,0,0,8'h00,4'd15,4'd5));
    exp_q.push_back(ev(1,0,1,1,0,1,0,0,8'h00,4'd15,4'd5));
    run(16'h3450, 5, 6, "ld_ack3_latency");

    exp_q.push_back(ev(0,0,1,1,0,0,0,0,8'h00,4'd8,4'd9));
    exp_q.push_back(ev(1,0,1,1,0,1,0,0,8'h00,4'd15,4'd9));
    run(16'h3890, 3, 4, "ld_ack1_latency");

    exp_q.push_back(ev(0,0,1,1,1,0,0,0,8'h00,4'd6,4'd7));
    repeat (3) exp_q.push_back(ev(0,0,1,1,1,0,0,0,8'h00,4'd6,4'd7));
    exp_q.push_back(ev(0,0,1,1,1,1,0,1,8'h00,4'd6,4'd7));
    run(16'h4670, 0, 7, "st_timeout_latency");

    exp_q.push_back(ev(0,0,0,0,0,1,0,1,8'h00,4'd0,4'd0));
    run(16'h7000, 0, 3, "illegal_latency");

    exp_q.push_back(ev(0,0,0,0,0,0,1,0,8'h00,4'd13,4'd12));
    run(16'h5000, 0, 3, "jmp_latency");

    // Reset during the first MEM_WAIT cycle of a load.
    exp_q.push_back(ev(0,0,1,1,0,0,0,0,8'h00,4'd1,4'd2));
    exp_q.push_back(ev(0,0,1,1,0,0,0,0,8'h00,4'd15,4'd2));
    accept(16'h3120);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ld_in_mem_wait", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", 32'(all_out), 32'h0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    check("late_ack_ignored", 32'(all_out), 32'h0);
    reset = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    check("ready_after_abort", {31'h0, instr_ready}, 32'h1);

    accept(16'hF000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("halted_set", {30'h0, halted, instr_ready}, 32'h2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!halted || instr_ready || (|obs)) bad++;
    end
    check("halt_terminal", bad, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("halt_reset_clears", 32'(all_out), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_halt_reset", {30'h0, halted, instr_ready}, 32'h1);

    repeat (2) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
